// File: rtl/barrel_shifter_8bit.sv
// Pipelined 8-bit barrel shifter: rotate left/right, logical and arithmetic shift right.
// Input capture register, then three logarithmic stages (by 1, 2 and 4); result appears 3 edges after acceptance.
module barrel_shifter_8bit #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] a,
    input  logic [2:0]        s,
    input  logic [1:0]        op,
    output logic [DATA_W-1:0] y,
    output logic              out_valid
);

    localparam logic [1:0] OP_ROL = 2'b00;
    localparam logic [1:0] OP_ROR = 2'b01;
    localparam logic [1:0] OP_LSR = 2'b10;
    localparam logic [1:0] OP_ASR = 2'b11;

    // One conditional step of k positions; sign is the original operand MSB used for arithmetic fill.
    function automatic logic [DATA_W-1:0] shift_step(
        input logic [DATA_W-1:0] d,
        input logic [1:0]        op_sel,
        input logic              sign,
        input logic              en,
        input int                k
    );
        logic [DATA_W-1:0] res;
        logic [DATA_W-1:0] fill;
        fill = ~({DATA_W{1'b1}} >> k);
        res  = d;
        if (en) begin
            case (op_sel)
                OP_ROL:  res = (d << k) | (d >> (DATA_W - k));
                OP_ROR:  res = (d >> k) | (d << (DATA_W - k));
                OP_LSR:  res = d >> k;
                OP_ASR:  res = (d >> k) | (sign ? fill : {DATA_W{1'b0}});
                default: res = d;
            endcase
        end
        return res;
    endfunction

    logic [DATA_W-1:0] data_p0, data_p1, data_p2;
    logic [2:0]        s_p0;
    logic [2:1]        s_p1;
    logic              s_p2;
    logic [1:0]        op_p0, op_p1, op_p2;
    logic              sign_p0, sign_p1, sign_p2;
    logic              vld_p0, vld_p1, vld_p2;

    // Stage p0: capture accepted operands
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p0  <= 1'b0;
            data_p0 <= '0;
            s_p0    <= '0;
            op_p0   <= '0;
            sign_p0 <= 1'b0;
        end else begin
            vld_p0 <= in_valid;
            if (in_valid) begin
                data_p0 <= a;
                s_p0    <= s;
                op_p0   <= op;
                sign_p0 <= a[DATA_W-1];
            end
        end
    end

    // Stage p1: step by 1 under s[0]
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1  <= 1'b0;
            data_p1 <= '0;
            s_p1    <= '0;
            op_p1   <= '0;
            sign_p1 <= 1'b0;
        end else begin
            vld_p1 <= vld_p0;
            if (vld_p0) begin
                data_p1 <= shift_step(data_p0, op_p0, sign_p0, s_p0[0], 1);
                s_p1    <= s_p0[2:1];
                op_p1   <= op_p0;
                sign_p1 <= sign_p0;
            end
        end
    end

    // Stage p2: step by 2 under s[1]
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p2  <= 1'b0;
            data_p2 <= '0;
            s_p2    <= 1'b0;
            op_p2   <= '0;
            sign_p2 <= 1'b0;
        end else begin
            vld_p2 <= vld_p1;
            if (vld_p1) begin
                data_p2 <= shift_step(data_p1, op_p1, sign_p1, s_p1[1], 2);
                s_p2    <= s_p1[2];
                op_p2   <= op_p1;
                sign_p2 <= sign_p1;
            end
        end
    end

    // Output stage: step by 4 under s[2]; y holds between results
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            y         <= '0;
        end else begin
            out_valid <= vld_p2;
            if (vld_p2) begin
                y <= shift_step(data_p2, op_p2, sign_p2, s_p2, 4);
            end
        end
    end

endmodule

// File: tb/tb_barrel_shifter_8bit.sv
// Directed bench for barrel_shifter_8bit: latency, each op, wrap/fill boundaries, streaming and reset.
module tb_barrel_shifter_8bit;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic [7:0] a;
    logic [2:0] s;
    logic [1:0] op;
    logic [7:0] y;
    logic       out_valid;

    int n_checks = 0;
    int n_fail   = 0;

    barrel_shifter_8bit #(.DATA_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .a         (a),
        .s         (s),
        .op        (op),
        .y         (y),
        .out_valid (out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drives one operation and samples the outputs at each negedge until one cycle past the result.
    task automatic run_single(input logic [7:0] av, input logic [2:0] sv, input logic [1:0] opv,
                              output logic early, output logic [7:0] y_res, output logic vld_res,
                              output logic [7:0] y_next, output logic vld_next);
        @(negedge clk);
        in_valid = 1'b1; a = av; s = sv; op = opv;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0; a = ~av; s = ~sv; op = ~opv;
        early = out_valid;
        @(posedge clk); @(negedge clk);
        early = early | out_valid;
        @(posedge clk); @(negedge clk);
        early = early | out_valid;
        @(posedge clk); @(negedge clk);
        y_res = y; vld_res = out_valid;
        @(posedge clk); @(negedge clk);
        y_next = y; vld_next = out_valid;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b1; a = 8'h5A; s = 3'd1; op = 2'b00;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        n_checks++;
        if (y !== 8'h00) begin n_fail++; $display("FAIL reset_y: got %h expected 00", y); end
        rst = 1'b0; in_valid = 1'b0;
        repeat (4) begin
            @(negedge clk);
            n_checks++;
            if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_discard_pulse: got %b expected 0", out_valid); end
        end
    endtask

    task automatic test_rotate_left();
        logic [7:0] av [3] = '{8'b10101010, 8'b10101110, 8'b11101011};
        logic [2:0] sv [3] = '{3'd1, 3'd2, 3'd3};
        logic [7:0] ev [3] = '{8'b01010101, 8'b10111010, 8'b01011111};
        logic e, v, vn; logic [7:0] yr, yn;
        for (int i = 0; i < 3; i++) begin
            run_single(av[i], sv[i], 2'b00, e, yr, v, yn, vn);
            n_checks++;
            if (e !== 1'b0) begin n_fail++; $display("FAIL rol_early_valid[%0d]: got %b expected 0", i, e); end
            n_checks++;
            if (v !== 1'b1) begin n_fail++; $display("FAIL rol_valid_lat3[%0d]: got %b expected 1", i, v); end
            n_checks++;
            if (yr !== ev[i]) begin n_fail++; $display("FAIL rol_y[%0d]: got %b expected %b", i, yr, ev[i]); end
            n_checks++;
            if (vn !== 1'b0 || yn !== ev[i]) begin
                n_fail++; $display("FAIL rol_pulse_hold[%0d]: got vld=%b y=%b expected vld=0 y=%b", i, vn, yn, ev[i]);
            end
        end
    endtask

    task automatic test_shift_right();
        logic [7:0] av [5] = '{8'b10100010, 8'b10111110, 8'b00101000, 8'h80, 8'h7F};
        logic [2:0] sv [5] = '{3'd4, 3'd5, 3'd6, 3'd7, 3'd7};
        logic [1:0] ov [5] = '{2'b10, 2'b11, 2'b11, 2'b11, 2'b10};
        logic [7:0] ev [5] = '{8'b00001010, 8'b11111101, 8'b00000000, 8'hFF, 8'h00};
        logic e, v, vn; logic [7:0] yr, yn;
        for (int i = 0; i < 5; i++) begin
            run_single(av[i], sv[i], ov[i], e, yr, v, yn, vn);
            n_checks++;
            if (e !== 1'b0 || v !== 1'b1 || vn !== 1'b0) begin
                n_fail++; $display("FAIL shr_valid_timing[%0d]: got early=%b at3=%b next=%b expected 0 1 0", i, e, v, vn);
            end
            n_checks++;
            if (yr !== ev[i]) begin n_fail++; $display("FAIL shr_y[%0d]: got %b expected %b", i, yr, ev[i]); end
        end
    endtask

    task automatic test_rotate_right();
        logic [7:0] av [3] = '{8'b00010100, 8'h81, 8'h01};
        logic [2:0] sv [3] = '{3'd7, 3'd0, 3'd3};
        logic [7:0] ev [3] = '{8'b00101000, 8'h81, 8'h20};
        logic e, v, vn; logic [7:0] yr, yn;
        for (int i = 0; i < 3; i++) begin
            run_single(av[i], sv[i], 2'b01, e, yr, v, yn, vn);
            n_checks++;
            if (v !== 1'b1 || yr !== ev[i]) begin
                n_fail++; $display("FAIL ror_y[%0d]: got vld=%b y=%b expected vld=1 y=%b", i, v, yr, ev[i]);
            end
        end
    endtask

    task automatic test_s_zero();
        logic e, v, vn; logic [7:0] yr, yn;
        for (int i = 0; i < 4; i++) begin
            run_single(8'hC3, 3'd0, 2'(i), e, yr, v, yn, vn);
            n_checks++;
            if (v !== 1'b1 || yr !== 8'hC3) begin
                n_fail++; $display("FAIL s_zero_op%0d: got vld=%b y=%h expected vld=1 y=c3", i, v, yr);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] av [8] = '{8'hA5, 8'h01, 8'hF0, 8'h7F, 8'h12, 8'h03, 8'hFF, 8'h80};
        logic [1:0] ov [8] = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b00, 2'b01, 2'b10, 2'b11};
        logic [7:0] ev [8] = '{8'hA5, 8'h80, 8'h3C, 8'h0F, 8'h21, 8'h18, 8'h03, 8'hFF};
        int j;
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            if (c >= 1) begin
                j = c - 4;
                if (j >= 0 && j < 8) begin
                    n_checks++;
                    if (out_valid !== 1'b1 || y !== ev[j]) begin
                        n_fail++; $display("FAIL stream[%0d]: got vld=%b y=%h expected vld=1 y=%h", j, out_valid, y, ev[j]);
                    end
                end else begin
                    n_checks++;
                    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL stream_idle_cycle%0d: got vld=%b expected 0", c, out_valid); end
                    if (j >= 8) begin
                        n_checks++;
                        if (y !== 8'hFF) begin n_fail++; $display("FAIL stream_hold_cycle%0d: got y=%h expected ff", c, y); end
                    end
                end
            end
            if (c < 8) begin
                in_valid = 1'b1; a = av[c]; s = 3'(c); op = ov[c];
            end else begin
                in_valid = 1'b0; a = 8'(c * 37); s = 3'(c); op = 2'(c);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic e, v, vn; logic [7:0] yr, yn;
        @(negedge clk);
        in_valid = 1'b1; a = 8'h0F; s = 3'd1; op = 2'b00;
        @(negedge clk);
        a = 8'hF0; s = 3'd2; op = 2'b01;
        @(negedge clk);
        rst = 1'b1; a = 8'h33; s = 3'd3; op = 2'b00;
        @(negedge clk);
        rst = 1'b0; in_valid = 1'b0;
        n_checks++;
        if (y !== 8'h00 || out_valid !== 1'b0) begin
            n_fail++; $display("FAIL midrst_clear: got vld=%b y=%h expected vld=0 y=00", out_valid, y);
        end
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            n_checks++;
            if (out_valid !== 1'b0 || y !== 8'h00) begin
                n_fail++; $display("FAIL midrst_no_pulse[%0d]: got vld=%b y=%h expected vld=0 y=00", k, out_valid, y);
            end
        end
        run_single(8'h96, 3'd2, 2'b00, e, yr, v, yn, vn);
        n_checks++;
        if (e !== 1'b0 || v !== 1'b1 || yr !== 8'h5A) begin
            n_fail++; $display("FAIL midrst_next: got early=%b vld=%b y=%h expected 0 1 5a", e, v, yr);
        end
    endtask

    initial begin
        rst = 1'b0; in_valid = 1'b0; a = '0; s = '0; op = '0;
        test_reset();
        test_rotate_left();
        test_shift_right();
        test_rotate_right();
        test_s_zero();
        test_back_to_back();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/barrel_shifter_8bit.md
BARREL_SHIFTER_8BIT -- requirements
Module: barrel_shifter_8bit

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8, data width; only 8 is required to work, and s width is fixed at 3.
REQ-002 The block SHALL have port clk, input, 1 bit, single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit, synchronous active-high reset sampled on the rising edge of clk.
REQ-004 The block SHALL have port in_valid, input, 1 bit; a, s and op are accepted on the clk edge where in_valid=1.
REQ-005 The block SHALL have port a, input, 8 bits, operand to shift or rotate.
REQ-006 The block SHALL have port s, input, 3 bits, shift amount 0..7.
REQ-007 The block SHALL have port op, input, 2 bits, operation select: 00 rotate left, 01 rotate right, 10 logical shift right (zero fill), 11 arithmetic shift right (fill with a[7]).
REQ-008 The block SHALL have port y, output, 8 bits, registered result.
REQ-009 The block SHALL have port out_valid, output, 1 bit, high for exactly one cycle per accepted input when y carries its result.

Function
REQ-010 The datapath SHALL be a 3-stage logarithmic pipeline: stage 1 conditionally shifts or rotates by 1 (s[0]), stage 2 by 2 (s[1]), and stage 3 by 4 (s[2]).
REQ-011 Each stage SHALL register its data, op, the remaining s bits and a valid bit, and SHALL carry the original sign bit a[7] for arithmetic fill.
REQ-012 Latency SHALL be exactly 3 cycles: an input accepted at edge N produces y and out_valid=1 after edge N+3.
REQ-013 Throughput SHALL be one operation per cycle; there is no backpressure, and the pipeline advances every cycle.
REQ-014 Stage registers SHALL load new data only when their incoming valid is 1; otherwise they hold their contents.
REQ-015 y SHALL hold the last valid result while out_valid=0.
REQ-016 With s=0, y SHALL equal a for every op.
REQ-017 Rotates SHALL wrap modulo 8 with no bit lost: rotate left by k equals rotate right by 8-k.
REQ-018 A logical shift right by k SHALL clear the top k bits.
REQ-019 An arithmetic shift right by k SHALL replicate a[7] into the top k bits; s=7 yields 8'h00 or 8'hFF.
REQ-020 Back-to-back inputs with differing op and s SHALL each produce their own correct result in order, with no interference between them.
REQ-021 Input values present while in_valid=0 SHALL have no effect on y or out_valid.

Reset
REQ-022 While rst=1 at a clk edge, all stage valids and out_valid SHALL become 0, and all stage data registers and y SHALL become 8'h00.
REQ-023 rst SHALL take priority over in_valid: an input presented in the same cycle as rst is discarded.
REQ-024 Reset in mid-operation SHALL discard all in-flight operations; no out_valid pulse SHALL appear for inputs accepted before the reset.
REQ-025 After rst deasserts, the first input accepted SHALL follow the normal 3-cycle latency.

Verification
REQ-026 Rotate left: a=8'b10101010, s=1, op=00 -> y=8'b01010101 with out_valid 3 cycles later; a=8'b10101110, s=2 -> 8'b10111010; a=8'b11101011, s=3 -> 8'b01011111.
REQ-027 Shift right: op=10, a=8'b10100010, s=4 -> 8'b00001010; op=11, a=8'b10111110, s=5 -> 8'b11111101; op=11, a=8'b00101000, s=6 -> 8'b00000000.
REQ-028 Rotate right wrap: op=01, a=8'b00010100, s=7 -> 8'b00101000; op=01, a=8'h81, s=0 -> 8'h81.
REQ-029 Streaming: eight consecutive valid inputs with s=0..7 and mixed op -> eight consecutive out_valid pulses with correct, in-order results; idle gaps produce no pulses and y holds its value.
REQ-030 Reset: assert rst for one cycle while two operations are in flight -> y=8'h00, out_valid stays 0 for those operations, and the next input emerges after 3 cycles.
